mul_d: RTL and testbench

- Iterative radix-4 unsigned multiplier for the Dilithium arithmetic path (q = 8380417).
- Sits directly upstream of the Barrett reduction stage red_D. It takes two 23-bit coefficients and produces the 46-bit product that red_D reduces.
- Uses a valid/ready handshake on both sides, so it can sit between a coefficient memory/NTT controller and the reduction stage.
- Operands are not assumed to be < q; the result is correct for any 23-bit pair.

---
 rtl/dil_pkg.sv | 17 +
 rtl/mul_d_pp.sv | 24 ++
 rtl/mul_d.sv | 112 +++++++++++
 tb/tb_mul_d.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dil_pkg.sv
// Shared types and constants for the Dilithium arithmetic path.
package dil_pkg;

    localparam int COEF_W = 23;
    localparam int PROD_W = 46;
    localparam logic [COEF_W-1:0] Q_D = 23'd8380417;

    typedef logic [COEF_W-1:0] coef_t;
    typedef logic [PROD_W-1:0] prod_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } mul_state_t;

endpackage

// File: rtl/mul_d_pp.sv
// Radix-4 digit select: maps a 2-bit multiplier digit to 0, b, 2b or 3b.
module mul_d_pp
    import dil_pkg::*;
#(
    parameter int WIDTH = COEF_W
) (
    input  logic [1:0]       d_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH+1:0] b3_i,
    output logic [WIDTH+1:0] pp_o
);

    always_comb begin
        pp_o = '0;
        unique case (d_i)
            2'd0: pp_o = '0;
            2'd1: pp_o = {2'b00, b_i};
            2'd2: pp_o = {1'b0, b_i, 1'b0};
            2'd3: pp_o = b3_i;
            default: pp_o = '0;
        endcase
    end

endmodule

// File: rtl/mul_d.sv
// Iterative radix-4 unsigned multiplier feeding the Barrett stage red_D.
// Two multiplier bits are retired per cycle; product bits shift into acc_lo.
module mul_d
    import dil_pkg::*;
#(
    parameter int WIDTH = COEF_W
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               valid_i,
    output logic               ready_o,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               valid_o,
    input  logic               ready_i,
    output logic [2*WIDTH-1:0] product_o
);

    localparam int ITER = (WIDTH + 1) / 2;
    localparam int AW   = 2 * ITER;
    localparam int BW   = WIDTH + 2;
    localparam int CW   = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    mul_state_t         state_q, state_d;
    logic [AW-1:0]      a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [BW-1:0]      b3_q, b3_d;
    logic [WIDTH:0]     hi_q, hi_d;
    logic [AW-1:0]      lo_q, lo_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [BW-1:0]      pp;
    logic [BW:0]        sum;

    mul_d_pp #(.WIDTH(WIDTH)) u_pp (
        .d_i  (a_q[1:0]),
        .b_i  (b_q),
        .b3_i (b3_q),
        .pp_o (pp)
    );

    // hi stays below 2b, so hi + 3b fits in BW+1 bits
    assign sum = (BW+1)'(hi_q) + (BW+1)'(pp);

    assign ready_o   = (state_q == IDLE);
    assign valid_o   = (state_q == DONE);
    assign product_o = prod_q;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        b3_d    = b3_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        unique case (state_q)
            IDLE: begin
                if (valid_i) begin
                    a_d     = AW'(a_i);
                    b_d     = b_i;
                    b3_d    = {2'b00, b_i} + {1'b0, b_i, 1'b0};
                    hi_d    = '0;
                    lo_d    = '0;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                a_d  = a_q >> 2;
                hi_d = sum[BW:2];
                lo_d = {sum[1:0], lo_q[AW-1:2]};
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    prod_d  = {sum[WIDTH:0], lo_q[AW-1:2]};
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                if (ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            b3_q    <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            b3_q    <= b3_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

endmodule

// File: tb/tb_mul_d.sv
// Self-checking bench for mul_d: directed table, corner sequences, random stream.
module tb_mul_d;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [22:0] a_i;
    logic [22:0] b_i;
    logic        valid_o;
    logic        ready_i;
    logic [45:0] product_o;

    int n_tests = 0;
    int n_fail  = 0;

    mul_d dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .a_i       (a_i),
        .b_i       (b_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .product_o (product_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [22:0] a;
        logic [22:0] b;
        logic [45:0] p;
    } vec_t;

    typedef struct {
        logic [22:0] a;
        logic [22:0] b;
    } pair_t;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [45:0] ref_mul(input logic [22:0] a,
                                            input logic [22:0] b);
        longint unsigned x;
        x = longint'(a) * longint'(b);
        return x[45:0];
    endfunction

    // Issue one pair with ready_i high; check latency and product, then pop.
    task automatic run_one(input logic [22:0] a, input logic [22:0] b,
                           input logic [45:0] exp, input string name);
        int cyc;
        cyc = 0;
        while (!ready_o && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_ready"}, ready_o, 1);
        valid_i = 1'b1;
        a_i = a;
        b_i = b;
        @(posedge clk); #1;
        valid_i = 1'b0;
        a_i = 23'($urandom);
        b_i = 23'($urandom);
        cyc = 0;
        while (!valid_o && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({name, "_latency"}, cyc, 12);
        check({name, "_prod"}, product_o, exp);
        @(posedge clk); #1;
    endtask

    vec_t  vt[8];
    pair_t sb[$];

    initial begin
        logic [45:0] held;
        logic        ok;
        logic        stale;
        int          pops;
        int          cyc;
        int          last_acc;
        bit          have_last;
        bit          acc;
        bit          pop;
        pair_t       pr;

        vt[0] = '{23'd1234,    23'd5678,    46'd7006652};
        vt[1] = '{23'd8380416, 23'd8380416, 46'd70231372333056};
        vt[2] = '{23'd8388607, 23'd8388607, 46'd70368727400449};
        vt[3] = '{23'd0,       23'd8388607, 46'd0};
        vt[4] = '{23'd8388607, 23'd0,       46'd0};
        vt[5] = '{23'd1,       23'd1,       46'd1};
        vt[6] = '{23'd3,       23'd8388607, 46'd25165821};
        vt[7] = '{23'd2,       23'd3,       46'd6};

        rst_n   = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        a_i     = '0;
        b_i     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_prod", product_o, 0);
        check("rst_ready", ready_o, 1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_one(vt[i].a, vt[i].b, vt[i].p, $sformatf("vec%0d", i));

        // Backpressure: result held, valid_i ignored while not ready.
        valid_i = 1'b1;
        a_i = 23'd4000000;
        b_i = 23'd3;
        @(posedge clk); #1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        cyc = 0;
        while (!valid_o && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("bp_latency", cyc, 12);
        held = product_o;
        check("bp_prod", held, 46'd12000000);
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (i == 10) begin
                valid_i = 1'b1;
                a_i = 23'd5;
                b_i = 23'd7;
            end else begin
                valid_i = 1'b0;
            end
            @(posedge clk); #1;
            if (product_o !== held || ready_o !== 1'b0 || valid_o !== 1'b1)
                ok = 1'b0;
        end
        valid_i = 1'b0;
        check("bp_hold", ok, 1);
        check("bp_prod_after", product_o, 46'd12000000);
        ready_i = 1'b1;
        @(posedge clk); #1;
        check("bp_pop_valid", valid_o, 0);
        check("bp_pop_ready", ready_o, 1);
        run_one(23'd5, 23'd7, 46'd35, "bp_next");

        // Reset in the middle of BUSY discards the operation.
        valid_i = 1'b1;
        a_i = 23'd1000;
        b_i = 23'd1000;
        @(posedge clk); #1;
        valid_i = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("mid_busy", ready_o, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("mr_valid", valid_o, 0);
        check("mr_prod", product_o, 0);
        check("mr_ready", ready_o, 1);
        stale = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            if (valid_o) stale = 1'b1;
        end
        check("mr_no_stale", stale, 0);
        run_one(23'd3, 23'd3, 46'd9, "mr_fresh");

        // Random stream with random backpressure against the queue model.
        pops = 0;
        cyc = 0;
        have_last = 1'b0;
        last_acc = 0;
        while (pops < 100 && cyc < 20000) begin
            @(negedge clk);
            valid_i = ($urandom_range(0, 9) < 7);
            ready_i = $urandom_range(0, 1);
            a_i = 23'($urandom);
            b_i = 23'($urandom);
            if ($urandom_range(0, 7) == 0) a_i = 23'h7fffff;
            if ($urandom_range(0, 7) == 0) b_i = 23'd0;
            acc = valid_i && ready_o;
            pop = valid_o && ready_i;
            if (acc) begin
                if (have_last)
                    check("stream_interval", (cyc - last_acc) >= 14, 1);
                have_last = 1'b1;
                last_acc = cyc;
                sb.push_back('{a_i, b_i});
            end
            if (pop) begin
                if (sb.size() == 0) begin
                    check("stream_dup", 1, 0);
                end else begin
                    pr = sb.pop_front();
                    check($sformatf("stream%0d", pops), product_o,
                          ref_mul(pr.a, pr.b));
                end
                pops++;
            end
            cyc++;
        end
        check("stream_count", pops, 100);
        @(negedge clk);
        valid_i = 1'b0;
        ready_i = 1'b1;
        repeat (16) @(posedge clk);
        #1;
        check("stream_drain", sb.size() <= 1, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
